// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: word size, bit ordering,
// receiver FSM states and the error-counter saturation value.
package serial_pkg;
  localparam int SERIAL_WORD_W = 32;
  localparam bit MSB_FIRST     = 1'b1;
  localparam logic [7:0] ERRCNT_SAT = 8'd255;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer of parameterized depth with a configurable reset value.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_q;

  // Shift the asynchronous pin through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= {STAGES{RST_VAL}};
    else          r_q <= {r_q[STAGES-2:0], i_d};
  end

  assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/serial_word_rx.sv
// Receive-side deserializer for the SS/SCLK/MOSI link. Oversamples all three
// pins, shifts one word per SS-low frame and reports good words (o_Valid) or
// frames with the wrong SCLK edge count (o_FrameErr).
// Optional: define SERIAL_RX_ERRCNT_EN to add the saturating o_ErrCount port.
module serial_word_rx
  import serial_pkg::*;
#(
  parameter int WIDTH       = SERIAL_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_SS,
  input  logic             i_SCLK,
  input  logic             i_MOSI,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Valid,
  output logic             o_FrameErr,
  output logic             o_Busy
`ifdef SERIAL_RX_ERRCNT_EN
  ,
  output logic [7:0]       o_ErrCount
`endif
);
  // One extra count value above WIDTH so overrun never aliases a good frame.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic w_ss_s, w_sclk_s, w_mosi_s;
  logic r_ss_d, r_sclk_d;
  logic w_ss_fall, w_ss_rise, w_sclk_rise;

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  // All three pins see identical latency so MOSI stays aligned with SCLK.
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .i_clk(i_Clock), .i_rst_n(i_Reset), .i_d(i_SS), .o_q(w_ss_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_Clock), .i_rst_n(i_Reset), .i_d(i_SCLK), .o_q(w_sclk_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_Clock), .i_rst_n(i_Reset), .i_d(i_MOSI), .o_q(w_mosi_s));

  // Delayed copies of the synchronized SS and SCLK for edge detection.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_ss_d   <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      r_ss_d   <= w_ss_s;
      r_sclk_d <= w_sclk_s;
    end
  end

  assign w_ss_fall   = r_ss_d & ~w_ss_s;
  assign w_ss_rise   = ~r_ss_d & w_ss_s;
  assign w_sclk_rise = ~r_sclk_d & w_sclk_s;

  // Next shift/count values; completion is judged on these so a final SCLK
  // edge coinciding with the SS rise is still counted.
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    if (w_sclk_rise) begin
      if (MSB_FIRST) w_shreg_nxt = {r_shreg[WIDTH-2:0], w_mosi_s};
      else           w_shreg_nxt = {w_mosi_s, r_shreg[WIDTH-1:1]};
      if (r_cnt != CNT_SAT) w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Frame FSM: IDLE waits for SS fall, SHIFT collects bits until SS rise.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      o_Data     <= '0;
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
    end else begin
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state <= SHIFT;
            r_shreg <= '0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_shreg <= w_shreg_nxt;
          r_cnt   <= w_cnt_nxt;
          if (w_ss_rise) begin
            r_state <= IDLE;
            if (w_cnt_nxt == CNT_FULL) begin
              o_Data  <= w_shreg_nxt;
              o_Valid <= 1'b1;
            end else begin
              o_FrameErr <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_Busy = (r_state == SHIFT);

`ifdef SERIAL_RX_ERRCNT_EN
  // Count error pulses, sticking at the saturation value until reset.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset)                               o_ErrCount <= 8'd0;
    else if (o_FrameErr && o_ErrCount != ERRCNT_SAT) o_ErrCount <= o_ErrCount + 8'd1;
  end
`endif
endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized scoreboard bench for serial_word_rx.
module tb_serial_word_rx;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic [W-1:0] data;
  logic valid, ferr, busy;
`ifdef SERIAL_RX_ERRCNT_EN
  logic [7:0] errcnt;
`endif

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_Clock(clk), .i_Reset(rst_n), .i_SS(ss), .i_SCLK(sclk), .i_MOSI(mosi),
    .o_Data(data), .o_Valid(valid), .o_FrameErr(ferr), .o_Busy(busy)
`ifdef SERIAL_RX_ERRCNT_EN
    , .o_ErrCount(errcnt)
`endif
  );

  typedef struct { bit err; logic [W-1:0] word; } exp_t;
  exp_t exp_q[$];
  logic [W-1:0] last_good = '0;
  int model_errs = 0;
  int checks = 0, fails = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever the DUT reports a frame outcome.
  always @(negedge clk) begin
    if (rst_n && (valid || ferr)) begin
      exp_t e;
      check("valid_ferr_exclusive", {31'd0, valid & ferr}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {31'd0, valid}, {31'd0, ~valid});
      end else begin
        e = exp_q.pop_front();
        check("event_kind_is_err", {31'd0, ferr}, {31'd0, e.err});
        if (!e.err) last_good = e.word;
        check(e.err ? "data_held_on_err" : "data_on_valid", data, last_good);
      end
    end
  end

  // One frame of n SCLK edges; bits beyond the word are random filler.
  task automatic frame(input logic [W-1:0] w, input int n, input bit close, input int gap);
    exp_t e;
    ss = 1'b0;
    cyc(4);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      mosi = (i < W) ? w[W-1-i] : 1'($urandom);
      cyc(4);
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
    end
    cyc(4);
    if (close) begin
      e.err = (n != W);
      e.word = w;
      if (e.err && model_errs < 255) model_errs++;
      exp_q.push_back(e);
      ss = 1'b1;
      cyc(gap);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin cyc(1); t++; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    cyc(2);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_errcnt();
`ifdef SERIAL_RX_ERRCNT_EN
    check("errcount", {24'd0, errcnt}, 32'(model_errs));
`endif
  endtask

  initial begin
    int lens[6];
    lens = '{30, 31, 32, 32, 33, 34};
    cyc(3);
    check("rst_data", data, '0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    cyc(6);

    frame(32'h6bc57a91, 32, 1, 6); drain();
    frame(32'h12345678, 31, 1, 6); drain();
    frame(32'h87654321, 33, 1, 6); drain();
    check("data_after_errs", data, 32'h6bc57a91);
    chk_errcnt();

    // Reset in the middle of a frame.
    frame(32'hDEADBEEF, 16, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_data", data, '0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_ferr", {31'd0, ferr}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    last_good = '0; model_errs = 0;
    chk_errcnt();
    ss = 1'b1; cyc(3);
    rst_n = 1'b1; cyc(6);
    frame(32'hA5A50F0F, 32, 1, 6); drain();

    // SS held low across reset release: the tail of that frame is ignored.
    ss = 1'b0; cyc(2);
    rst_n = 1'b0; cyc(3);
    rst_n = 1'b1; cyc(6);
    for (int i = 0; i < 5; i++) begin sclk = 1'b1; cyc(4); sclk = 1'b0; cyc(4); end
    ss = 1'b1; cyc(20);
    check("no_event_after_stale", 32'(exp_q.size()), 32'd0);
    check("stale_data_zero", data, '0);
    frame(32'hC0FFEE11, 32, 1, 6); drain();

    // Back-to-back with minimum SS-high gap.
    frame(32'h00000001, 32, 1, 3);
    frame(32'hFFFFFFFF, 32, 1, 6);
    drain();

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      frame($urandom, lens[$urandom_range(5, 0)], 1, 3 + $urandom_range(4, 0));
    end
    drain();
    chk_errcnt();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Receive-side deserializer for the three-wire serial link driven by `SerialCTL`. Oversamples SS, SCLK and MOSI in the local `Clock` domain, shifts in one word per SS frame MSB-first, and presents the word with a one-cycle `Valid` strobe. Malformed frames raise `FrameErr` instead. It sits directly downstream of `SerialCTL` on the same board, or on the remote device at the far end of the link.

## Interface
- `WIDTH`, 32: bits per frame; must match the transmitter word size.
- `SYNC_STAGES`, 2: synchronizer flops per input pin; minimum 2.
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous assert, active-low (0 = reset); release is synchronized externally.
- `SS` in 1: frame select, active-low, asynchronous to `Clock`.
- `SCLK` in 1: serial clock, idles low, asynchronous to `Clock`.
- `MOSI` in 1: serial data, MSB first.
- `Data` out WIDTH: last good word; holds its value until the next good frame.
- `Valid` out 1: one-cycle pulse when `Data` updates.
- `FrameErr` out 1: one-cycle pulse when a frame ends with the wrong edge count.
- `Busy` out 1: high while state is SHIFT.
- `ErrCount` out 8: present only with `SERIAL_RX_ERRCNT_EN`.

## Operation
- Each pin passes through its own `SYNC_STAGES` chain. In the reset values below, "s" denotes the synchronized version of a pin.
  - SS chain resets to 0.
  - SCLK chain resets to 0.
  - MOSI chain resets to 0.
- Edge detect compares the last sync stage against one extra registered copy.
- States:
  - IDLE: all outputs quiet. A falling edge on sSS moves to SHIFT and clears the shift register and count.
  - SHIFT: on each sSCLK rising edge, `shreg <= {shreg[WIDTH-2:0], sMOSI}`. Count increments and saturates at WIDTH+1. A rising edge on sSS moves to IDLE:
    - If count == WIDTH: `Data <= shreg`, `Valid` = 1.
    - Otherwise: `FrameErr` = 1 and `Data` is unchanged.
- Count width is `$clog2(WIDTH+2)`, so overrun (more than WIDTH edges) is distinguishable from a good frame.
- If an sSCLK rise and an sSS rise land in the same cycle, the shift and count update are applied first. Completion is then judged on the updated count.
- A frame in progress when `Reset` is released is ignored. Because the SS chain resets to 0, no falling edge is seen, and the block waits for SS high then low.
- Reset mid-frame: everything returns to reset values at once, and the partial word is discarded.
- Reset values: `Data` = 0, `Valid` = 0, `FrameErr` = 0, `Busy` = 0, `ErrCount` = 0, state = IDLE.

## Timing
- Pin-to-detect latency is SYNC_STAGES+1 `Clock` cycles, identical for all three pins. MOSI therefore stays aligned to SCLK.
- The transmitter must meet all of the following, measured in `Clock` periods:
  - SCLK high ≥ SYNC_STAGES+1.
  - SCLK low ≥ SYNC_STAGES+1.
  - MOSI setup to SCLK rise ≥ 2.
  - MOSI hold after SCLK rise ≥ 2.
  - SS high between frames ≥ SYNC_STAGES+1.
- `Valid`/`FrameErr` are asserted SYNC_STAGES+2 cycles after the SS pin rises. They are registered, high for exactly one cycle, and never both high at once.
- `Data` changes in the same cycle that `Valid` is high.
- `Busy` rises SYNC_STAGES+2 cycles after the SS pin falls.
- Back-to-back frames are accepted with no dead cycles beyond the SS-high minimum.

## Configuration
- `SERIAL_RX_ERRCNT_EN` defined:
  - The `ErrCount` port exists.
  - It increments on every `FrameErr` and saturates at 255.
  - It clears only on reset.
- Not defined:
  - The port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Package `serial_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - `SERIAL_WORD_W` = 32, shared with `SerialCTL`;
  - the MSB-first ordering constant;
  - the saturation constant for `ErrCount`.
- One sub-module, `sync_bit`, is instantiated three times. It is a parameterized-depth synchronizer with a reset-value parameter.

## Test plan
- Drive a 32-edge frame carrying 0x6bc57a91 (SCLK period 8 `Clock` cycles): `Data` = 0x6bc57a91, one `Valid` pulse, `FrameErr` stays 0.
- Send a 31-edge frame after a good frame: one `FrameErr` pulse, `Data` still 0x6bc57a91, no `Valid`.
- Send a 33-edge frame: `FrameErr` = 1, `Data` unchanged. With `SERIAL_RX_ERRCNT_EN`, `ErrCount` = 2 after this and the previous short frame.
- Assert `Reset` low after 16 edges: all outputs are 0 immediately. The following full frame of 0xA5A5_0F0F yields a `Valid` with that value.
- Hold SS low across `Reset` release, then raise SS: no `Valid` and no `FrameErr`. The next frame is received correctly.
- Send two frames separated by exactly the SS-high minimum, carrying 0x00000001 then 0xFFFFFFFF: two `Valid` pulses with the correct words.
